// File: rtl/p2p_pkg.sv
// Shared definitions for the point-to-point link node: channel limits,
// a constant-foldable clog2 helper and the layout of a link flit.
package p2p_pkg;

    localparam int MAX_CHAN = 16;

    // A flit is packed as {chan, data}; data sits at the bottom.
    localparam int FLIT_DATA_LSB = 0;

    function automatic int flit_chan_lsb(input int data_width);
        return data_width;
    endfunction

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/p2p_fifo.sv
// Show-ahead FIFO with wrap-bit pointers. A push while full and a pop while
// empty are ignored, so callers may drive push/pop without pre-gating.
module p2p_fifo
    import p2p_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra top bit distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/p2p_link_node.sv
// One endpoint of a two-node link: N transmit FIFOs share the outgoing link
// through a round-robin arbiter, and the incoming link is demultiplexed into
// N receive FIFOs. Per-channel rx_ready is the far node's credit signal.
module p2p_link_node
    import p2p_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           tx_valid,
    output logic [CW-1:0]  tx_chan,
    output logic [W-1:0]   tx_data,
    input  logic [N-1:0]   tx_ready,
    input  logic           rx_valid,
    input  logic [CW-1:0]  rx_chan,
    input  logic [W-1:0]   rx_data,
    output logic [N-1:0]   rx_ready,
    output logic [N-1:0]   out_valid,
    output logic [N*W-1:0] out_data,
    input  logic [N-1:0]   out_ready,
    output logic           ovf_err
);

    logic [N-1:0]    tx_full;
    logic [N-1:0]    tx_empty;
    logic [N-1:0]    tx_pop;
    logic [N-1:0]    eligible;
    logic [N-1:0]    rx_full;
    logic [N-1:0]    rx_empty;
    logic [N-1:0]    rx_push;
    logic [N-1:0]    rx_pop;
    logic [W-1:0]    tx_head [N];
    logic [W-1:0]    rx_head [N];
    logic [CW-1:0]   rr_ptr;
    logic [CW-1:0]   gnt_chan;
    logic            gnt_valid;
    logic [W-1:0]    gnt_data;
    logic            xfer;
    logic            rx_drop;
    logic [CW+W-1:0] tx_flit;
    int              arb_idx;

    // An out-of-range channel count names a module that does not exist,
    // which stops elaboration instead of building a broken node.
    if (N < 2 || N > MAX_CHAN) begin : g_bad_n
        p2p_illegal_channel_count u_bad ();
    end

    for (genvar c = 0; c < N; c++) begin : g_chan
        p2p_fifo #(.W(W), .DEPTH(DEPTH)) u_tx_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (in_valid[c]),
            .pop   (tx_pop[c]),
            .din   (in_data[c*W +: W]),
            .full  (tx_full[c]),
            .empty (tx_empty[c]),
            .head  (tx_head[c])
        );

        p2p_fifo #(.W(W), .DEPTH(DEPTH)) u_rx_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (rx_push[c]),
            .pop   (rx_pop[c]),
            .din   (rx_data),
            .full  (rx_full[c]),
            .empty (rx_empty[c]),
            .head  (rx_head[c])
        );

        assign tx_pop[c]          = xfer && (gnt_chan == CW'(c));
        assign rx_push[c]         = rx_valid && (rx_chan == CW'(c));
        assign rx_pop[c]          = out_ready[c] && !rx_empty[c];
        assign out_data[c*W +: W] = rx_head[c];
    end

    assign in_ready  = ~tx_full;
    assign rx_ready  = ~rx_full;
    assign out_valid = ~rx_empty;
    assign eligible  = ~tx_empty & tx_ready;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_chan  = '0;
        arb_idx   = 0;
        for (int i = 1; i <= N; i++) begin
            arb_idx = (int'(rr_ptr) + i) % N;
            if (!gnt_valid && eligible[arb_idx]) begin
                gnt_valid = 1'b1;
                gnt_chan  = CW'(arb_idx);
            end
        end
    end

    // Select the granted head and decide whether the far node accepts it.
    always_comb begin
        gnt_data = '0;
        xfer     = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (gnt_valid && gnt_chan == CW'(c)) begin
                gnt_data = tx_head[c];
                xfer     = tx_ready[c];
            end
        end
    end

    assign tx_flit  = {gnt_chan, gnt_data};
    assign tx_valid = gnt_valid;
    assign tx_chan  = tx_flit[flit_chan_lsb(W) +: CW];
    assign tx_data  = tx_flit[FLIT_DATA_LSB +: W];

    // Remember the last channel that actually moved a flit.
    always_ff @(posedge clk) begin
        if (!rst_n)    rr_ptr <= CW'(N - 1);
        else if (xfer) rr_ptr <= gnt_chan;
    end

    // Detect a flit aimed at a full receive FIFO; such a flit is dropped.
    always_comb begin
        rx_drop = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (rx_valid && rx_chan == CW'(c) && rx_full[c]) rx_drop = 1'b1;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n)       ovf_err <= 1'b0;
        else if (rx_drop) ovf_err <= 1'b1;
    end

endmodule

// File: tb/tb_p2p_link_node.sv
// Two cross-connected link nodes. Node a is the sender under test, node b the
// receiver. hold_tx masks a's credit view, rx_force lets the bench drive a's
// receive port directly.
module tb_p2p_link_node;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;

    logic [N-1:0]   a_in_valid, a_in_ready, a_tx_ready, a_rx_ready, a_out_valid, a_out_ready;
    logic [N*W-1:0] a_in_data, a_out_data;
    logic           a_tx_valid, a_rx_valid, a_ovf;
    logic [CW-1:0]  a_tx_chan, a_rx_chan;
    logic [W-1:0]   a_tx_data, a_rx_data;

    logic [N-1:0]   b_in_valid, b_in_ready, b_tx_ready, b_rx_ready, b_out_valid, b_out_ready;
    logic [N*W-1:0] b_in_data, b_out_data;
    logic           b_tx_valid, b_ovf;
    logic [CW-1:0]  b_tx_chan;
    logic [W-1:0]   b_tx_data;

    logic           hold_tx, rx_force, f_valid;
    logic [CW-1:0]  f_chan;
    logic [W-1:0]   f_data;

    always #5 clk = ~clk;

    assign a_tx_ready = hold_tx ? '0 : b_rx_ready;
    assign b_tx_ready = a_rx_ready;
    assign a_rx_valid = rx_force ? f_valid : b_tx_valid;
    assign a_rx_chan  = rx_force ? f_chan  : b_tx_chan;
    assign a_rx_data  = rx_force ? f_data  : b_tx_data;

    p2p_link_node #(.N(N), .W(W), .DEPTH(DEPTH)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .tx_valid(a_tx_valid), .tx_chan(a_tx_chan), .tx_data(a_tx_data), .tx_ready(a_tx_ready),
        .rx_valid(a_rx_valid), .rx_chan(a_rx_chan), .rx_data(a_rx_data), .rx_ready(a_rx_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .ovf_err(a_ovf)
    );

    p2p_link_node #(.N(N), .W(W), .DEPTH(DEPTH)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .tx_valid(b_tx_valid), .tx_chan(b_tx_chan), .tx_data(b_tx_data), .tx_ready(b_tx_ready),
        .rx_valid(a_tx_valid), .rx_chan(a_tx_chan), .rx_data(a_tx_data), .rx_ready(b_rx_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .ovf_err(b_ovf)
    );

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++;
        if (a_in_ready !== 4'hF) $display("[TB] FAIL reset_in_ready got %h want %h", a_in_ready, 4'hF); else passes++;
        checks++;
        if (a_tx_valid !== 1'b0) $display("[TB] FAIL reset_tx_valid got %b want 0", a_tx_valid); else passes++;
        checks++;
        if (b_out_valid !== 4'h0) $display("[TB] FAIL reset_out_valid got %h want 0", b_out_valid); else passes++;
        checks++;
        if (a_ovf !== 1'b0) $display("[TB] FAIL reset_ovf got %b want 0", a_ovf); else passes++;
        checks++;
        if (b_rx_ready !== 4'hF) $display("[TB] FAIL reset_rx_ready got %h want %h", b_rx_ready, 4'hF); else passes++;
        checks++;
        if ({a_tx_chan, a_tx_data} !== 10'h0) $display("[TB] FAIL reset_tx_fields got %h want 0", {a_tx_chan, a_tx_data}); else passes++;
        checks++;
        if (b_out_data !== 32'h0) $display("[TB] FAIL reset_out_data got %h want 0", b_out_data); else passes++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_word();
        a_in_data        = '0;
        a_in_data[23:16] = 8'hA5;
        a_in_valid       = 4'b0100;
        step();
        a_in_valid = '0;
        checks++;
        if (a_tx_valid !== 1'b1 || a_tx_chan !== 2'd2) $display("[TB] FAIL single_tx got v=%b ch=%0d want v=1 ch=2", a_tx_valid, a_tx_chan); else passes++;
        checks++;
        if (a_tx_data !== 8'hA5) $display("[TB] FAIL single_tx_data got %h want a5", a_tx_data); else passes++;
        checks++;
        if (b_out_valid !== 4'h0) $display("[TB] FAIL single_early_out got %h want 0", b_out_valid); else passes++;
        step();
        checks++;
        if (b_out_valid !== 4'b0100 || b_out_data[23:16] !== 8'hA5) $display("[TB] FAIL single_out got v=%h d=%h want v=4 d=a5", b_out_valid, b_out_data[23:16]); else passes++;
        checks++;
        if (a_tx_valid !== 1'b0) $display("[TB] FAIL single_tx_idle got %b want 0", a_tx_valid); else passes++;
        b_out_ready[2] = 1'b1;
        step();
        b_out_ready = '0;
        checks++;
        if (b_out_valid !== 4'h0) $display("[TB] FAIL single_popped got %h want 0", b_out_valid); else passes++;
    endtask

    task automatic test_fairness();
        logic [CW-1:0] exp_c;
        logic [W-1:0]  exp_d;
        rst_n = 1'b0;
        step();
        rst_n       = 1'b1;
        hold_tx     = 1'b1;
        b_out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 4'hF;
            for (int c = 0; c < N; c++) a_in_data[c*W +: W] = 8'(16 * c + i);
            step();
        end
        a_in_valid = '0;
        checks++;
        if (a_in_ready !== 4'h0) $display("[TB] FAIL fair_preload_full got %h want 0", a_in_ready); else passes++;
        checks++;
        if (a_tx_valid !== 1'b0) $display("[TB] FAIL fair_hold_tx got %b want 0", a_tx_valid); else passes++;
        hold_tx = 1'b0;
        #1;
        for (int k = 0; k < 16; k++) begin
            exp_c = CW'(k % 4);
            exp_d = 8'(16 * (k % 4) + k / 4);
            checks++;
            if (a_tx_valid !== 1'b1 || a_tx_chan !== exp_c || a_tx_data !== exp_d)
                $display("[TB] FAIL fair_grant_%0d got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", k, a_tx_valid, a_tx_chan, a_tx_data, exp_c, exp_d);
            else passes++;
            step();
            checks++;
            if (b_out_valid !== (4'b1 << exp_c) || b_out_data[exp_c*W +: W] !== exp_d)
                $display("[TB] FAIL fair_deliver_%0d got v=%h d=%h want v=%h d=%h", k, b_out_valid, b_out_data[exp_c*W +: W], 4'b1 << exp_c, exp_d);
            else passes++;
        end
        checks++;
        if (a_tx_valid !== 1'b0 || a_in_ready !== 4'hF) $display("[TB] FAIL fair_drained got v=%b rdy=%h want v=0 rdy=f", a_tx_valid, a_in_ready); else passes++;
        step();
    endtask

    task automatic test_backpressure();
        int n;
        int cyc;
        b_out_ready = 4'b1101;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_in_ready[1] !== 1'b1) $display("[TB] FAIL bp_accept_%0d got %b want 1", i, a_in_ready[1]); else passes++;
            a_in_valid       = 4'b0010;
            a_in_data[15:8]  = 8'(8'h40 + i);
            step();
        end
        a_in_valid = '0;
        checks++;
        if (a_in_ready[1] !== 1'b0 || b_rx_ready[1] !== 1'b0) $display("[TB] FAIL bp_stalled got in_rdy=%b rx_rdy=%b want 0 0", a_in_ready[1], b_rx_ready[1]); else passes++;
        checks++;
        if (a_tx_valid !== 1'b0) $display("[TB] FAIL bp_link_idle got %b want 0", a_tx_valid); else passes++;
        checks++;
        if (b_out_valid[1] !== 1'b1 || b_out_data[15:8] !== 8'h40) $display("[TB] FAIL bp_far_head got v=%b d=%h want v=1 d=40", b_out_valid[1], b_out_data[15:8]); else passes++;
        for (int j = 0; j < 4; j++) begin
            a_in_valid       = 4'b1000;
            a_in_data[31:24] = 8'(8'hC0 + j);
            step();
            checks++;
            if (a_tx_valid !== 1'b1 || a_tx_chan !== 2'd3 || a_tx_data !== 8'(8'hC0 + j))
                $display("[TB] FAIL bp_ch3_tx_%0d got v=%b ch=%0d d=%h want v=1 ch=3 d=%h", j, a_tx_valid, a_tx_chan, a_tx_data, 8'(8'hC0 + j));
            else passes++;
            if (j > 0) begin
                checks++;
                if (b_out_valid[3] !== 1'b1 || b_out_data[31:24] !== 8'(8'hC0 + j - 1))
                    $display("[TB] FAIL bp_ch3_out_%0d got v=%b d=%h want v=1 d=%h", j, b_out_valid[3], b_out_data[31:24], 8'(8'hC0 + j - 1));
                else passes++;
            end
        end
        a_in_valid  = '0;
        b_out_ready = 4'hF;
        n   = 0;
        cyc = 0;
        while (n < 8 && cyc < 60) begin
            if (b_out_valid[1]) begin
                checks++;
                if (b_out_data[15:8] !== 8'(8'h40 + n)) $display("[TB] FAIL bp_order_%0d got %h want %h", n, b_out_data[15:8], 8'(8'h40 + n)); else passes++;
                n++;
            end
            step();
            cyc++;
        end
        checks++;
        if (n !== 8) $display("[TB] FAIL bp_delivered got %0d want 8", n); else passes++;
        checks++;
        if (a_ovf !== 1'b0 || b_ovf !== 1'b0) $display("[TB] FAIL bp_ovf got a=%b b=%b want 0 0", a_ovf, b_ovf); else passes++;
        repeat (4) step();
    endtask

    task automatic test_wrap();
        logic [W-1:0] q[$];
        logic [W-1:0] d;
        logic         do_push;
        logic         do_pop;
        rx_force    = 1'b1;
        f_valid     = 1'b0;
        f_chan      = 2'd0;
        a_out_ready = '0;
        for (int it = 0; it < 100; it++) begin
            checks++;
            if (a_out_valid[0] !== (q.size() != 0)) $display("[TB] FAIL wrap_empty_%0d got %b want %b", it, a_out_valid[0], q.size() != 0); else passes++;
            checks++;
            if (a_rx_ready[0] !== (q.size() != DEPTH)) $display("[TB] FAIL wrap_full_%0d got %b want %b", it, a_rx_ready[0], q.size() != DEPTH); else passes++;
            if (q.size() != 0) begin
                checks++;
                if (a_out_data[7:0] !== q[0]) $display("[TB] FAIL wrap_head_%0d got %h want %h", it, a_out_data[7:0], q[0]); else passes++;
            end
            if (it < 50) begin
                do_push = ($urandom_range(0, 3) != 0) && (q.size() < DEPTH);
                do_pop  = ($urandom_range(0, 3) == 0);
            end else begin
                do_push = ($urandom_range(0, 3) == 0) && (q.size() < DEPTH);
                do_pop  = ($urandom_range(0, 3) != 0);
            end
            d              = 8'($urandom);
            f_valid        = do_push;
            f_data         = d;
            a_out_ready[0] = do_pop;
            step();
            if (do_pop && q.size() != 0) void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        f_valid     = 1'b0;
        a_out_ready = '0;
        checks++;
        if (a_ovf !== 1'b0) $display("[TB] FAIL wrap_ovf got %b want 0", a_ovf); else passes++;
        while (q.size() < DEPTH) begin
            d       = 8'($urandom);
            f_valid = 1'b1;
            f_data  = d;
            step();
            q.push_back(d);
        end
        f_valid = 1'b0;
        checks++;
        if (a_rx_ready[0] !== 1'b0) $display("[TB] FAIL ovf_full got %b want 0", a_rx_ready[0]); else passes++;
        f_valid = 1'b1;
        f_data  = 8'hEE;
        step();
        f_valid = 1'b0;
        checks++;
        if (a_ovf !== 1'b1) $display("[TB] FAIL ovf_flag got %b want 1", a_ovf); else passes++;
        a_out_ready[0] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (a_out_valid[0] !== 1'b1 || a_out_data[7:0] !== q[i]) $display("[TB] FAIL ovf_drain_%0d got v=%b d=%h want v=1 d=%h", i, a_out_valid[0], a_out_data[7:0], q[i]); else passes++;
            step();
        end
        a_out_ready = '0;
        checks++;
        if (a_out_valid[0] !== 1'b0 || a_ovf !== 1'b1) $display("[TB] FAIL ovf_dropped got v=%b ovf=%b want v=0 ovf=1", a_out_valid[0], a_ovf); else passes++;
        rx_force = 1'b0;
        step();
    endtask

    task automatic test_reset_midstream();
        b_out_ready = '0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid     = 4'b0001;
            a_in_data[7:0] = 8'(8'h70 + i);
            step();
        end
        a_in_valid = '0;
        checks++;
        if (b_out_valid[0] !== 1'b1 || a_tx_valid !== 1'b1) $display("[TB] FAIL mid_buffered got out=%b tx=%b want 1 1", b_out_valid[0], a_tx_valid); else passes++;
        rst_n = 1'b0;
        step();
        checks++;
        if (a_tx_valid !== 1'b0 || a_tx_data !== 8'h00) $display("[TB] FAIL mid_tx_cleared got v=%b d=%h want 0 00", a_tx_valid, a_tx_data); else passes++;
        checks++;
        if (a_in_ready !== 4'hF || b_rx_ready !== 4'hF) $display("[TB] FAIL mid_ready got in=%h rx=%h want f f", a_in_ready, b_rx_ready); else passes++;
        checks++;
        if (b_out_valid !== 4'h0 || b_out_data !== 32'h0) $display("[TB] FAIL mid_out_cleared got v=%h d=%h want 0 0", b_out_valid, b_out_data); else passes++;
        checks++;
        if (a_ovf !== 1'b0) $display("[TB] FAIL mid_ovf_cleared got %b want 0", a_ovf); else passes++;
        rst_n       = 1'b1;
        b_out_ready = 4'hF;
        step();
        checks++;
        if (b_out_valid !== 4'h0 || a_tx_valid !== 1'b0) $display("[TB] FAIL mid_no_stale got out=%h tx=%b want 0 0", b_out_valid, a_tx_valid); else passes++;
    endtask

    initial begin
        rst_n       = 1'b0;
        a_in_valid  = '0;
        a_in_data   = '0;
        a_out_ready = '0;
        b_in_valid  = '0;
        b_in_data   = '0;
        b_out_ready = '0;
        hold_tx     = 1'b0;
        rx_force    = 1'b0;
        f_valid     = 1'b0;
        f_chan      = '0;
        f_data      = '0;
        test_reset();
        test_single_word();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
